// File: rtl/mem_arbiter_rr_if.sv
// Port-side and memory-side bus of the frame-aware write arbiter.
// Handshake: a port raises i_en_port[k] together with its word (data, info,
// extra byte). It keeps the word and i_en_port[k] stable until the first cycle in
// which o_ack[k]=1. That cycle consumes the word. o_ack is combinational.
interface mem_arbiter_rr_if #(
  parameter int pPORT_NUM   = 3,
  parameter int pDATA_WIDTH = 32
);
  localparam int PW = $clog2(pPORT_NUM);

  logic [pPORT_NUM-1:0]             i_en_port;
  logic [pPORT_NUM*pDATA_WIDTH-1:0] i_data;
  logic [2*pPORT_NUM-1:0]           i_info;
  logic [2*pPORT_NUM-1:0]           i_extra_byte;
  logic [pPORT_NUM-1:0]             o_ack;
  logic [pDATA_WIDTH-1:0]           o_data;
  logic [PW-1:0]                    o_port_num;
  logic                             o_en_mem;
  logic [1:0]                       o_info_port;
  logic [1:0]                       o_extra_byte;
  logic                             o_abort;
  logic                             o_drop;
  // Debug view of the arbitration FSM: locked flag and current owner.
  logic                             dbg_locked;
  logic [PW-1:0]                    dbg_owner;

  modport master (
    output i_en_port, i_data, i_info, i_extra_byte,
    input  o_ack, o_data, o_port_num, o_en_mem, o_info_port, o_extra_byte,
           o_abort, o_drop, dbg_locked, dbg_owner
  );

  modport slave (
    input  i_en_port, i_data, i_info, i_extra_byte,
    output o_ack, o_data, o_port_num, o_en_mem, o_info_port, o_extra_byte,
           o_abort, o_drop, dbg_locked, dbg_owner
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Frame-aware round-robin write arbiter in front of the shared packet buffer.
// A port that wins with a start word owns the write path until its end word,
// so frames never interleave in the bank. Stalled owners are aborted after
// pTIMEOUT idle cycles; stray middle/end words seen while idle are dropped.
module mem_arbiter_rr #(
  parameter int pPORT_NUM   = 3,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 64
) (
  input logic             i_clk,
  input logic             i_reset,
  mem_arbiter_rr_if.slave bus
);
  localparam int PW = $clog2(pPORT_NUM);
  localparam int TW = $clog2(pTIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [PW-1:0]          last_q, last_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [1:0]             info_a [pPORT_NUM];
  logic [1:0]             xb_a   [pPORT_NUM];
  logic [pDATA_WIDTH-1:0] data_a [pPORT_NUM];
  logic [pPORT_NUM-1:0]   start_v;
  logic [pPORT_NUM-1:0]   orphan_v;

  logic [pPORT_NUM-1:0]   ack_c;
  logic                   wr_c, drop_c, abort_c, found_c;
  logic [PW-1:0]          sel_c, win_c;
  logic [1:0]             info_c;
  int                     sum_c;

  // Per-port views of the flat buses; info bit 0 separates frame openers
  // (01 start, 11 single) from words that only make sense inside a frame.
  for (genvar g = 0; g < pPORT_NUM; g++) begin : g_port
    assign info_a[g]   = bus.i_info[2*g +: 2];
    assign xb_a[g]     = bus.i_extra_byte[2*g +: 2];
    assign data_a[g]   = bus.i_data[g*pDATA_WIDTH +: pDATA_WIDTH];
    assign start_v[g]  = bus.i_en_port[g] & info_a[g][0];
    assign orphan_v[g] = bus.i_en_port[g] & ~info_a[g][0];
  end

  // Next-state, grant and ack: rotating priority search while idle, owner-only while locked.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    ack_c   = '0;
    wr_c    = 1'b0;
    drop_c  = 1'b0;
    abort_c = 1'b0;
    found_c = 1'b0;
    win_c   = '0;
    sel_c   = owner_q;
    info_c  = 2'b00;
    sum_c   = 0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 1; k <= pPORT_NUM; k++) begin
          sum_c = int'(last_q) + k;
          if (sum_c >= pPORT_NUM) sum_c = sum_c - pPORT_NUM;
          if (!found_c && start_v[PW'(sum_c)]) begin
            found_c = 1'b1;
            win_c   = PW'(sum_c);
          end
        end
        ack_c  = orphan_v;
        drop_c = |orphan_v;
        if (found_c) begin
          ack_c[win_c] = 1'b1;
          wr_c         = 1'b1;
          sel_c        = win_c;
          info_c       = info_a[win_c];
          last_d       = win_c;
          if (info_a[win_c] == 2'b01) begin
            state_d = ST_LOCKED;
            owner_d = win_c;
            tmo_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.i_en_port[owner_q]) begin
          ack_c[owner_q] = 1'b1;
          wr_c           = 1'b1;
          sel_c          = owner_q;
          tmo_d          = '0;
          // A fresh start inside a frame closes the old frame as an end word.
          info_c = (info_a[owner_q] == 2'b01) ? 2'b10 : info_a[owner_q];
          if (info_a[owner_q] != 2'b00) state_d = ST_IDLE;
        end else if (tmo_q == TW'(pTIMEOUT - 1)) begin
          abort_c = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration state: FSM, owner, round-robin pointer, stall counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= PW'(pPORT_NUM - 1);
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Memory-side output register; data fields hold when nothing is written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bus.o_en_mem     <= 1'b0;
      bus.o_abort      <= 1'b0;
      bus.o_drop       <= 1'b0;
      bus.o_data       <= '0;
      bus.o_port_num   <= '0;
      bus.o_info_port  <= 2'b00;
      bus.o_extra_byte <= 2'b00;
    end else begin
      bus.o_en_mem <= wr_c;
      bus.o_abort  <= abort_c;
      bus.o_drop   <= drop_c;
      if (wr_c) begin
        bus.o_data       <= data_a[sel_c];
        bus.o_port_num   <= sel_c;
        bus.o_info_port  <= info_c;
        bus.o_extra_byte <= xb_a[sel_c];
      end
    end
  end

  // Acks are forced low while reset is held so no word is consumed then.
  assign bus.o_ack      = ack_c & {pPORT_NUM{i_reset}};
  assign bus.dbg_locked = (state_q == ST_LOCKED);
  assign bus.dbg_owner  = owner_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios plus randomized frame traffic,
// all checked against a word-level reference model of the arbitration rules.
module tb_mem_arbiter_rr;
  localparam int N   = 3;
  localparam int W   = 32;
  localparam int TMO = 4;
  localparam int PW  = $clog2(N);
  localparam int TPW = PW + 2 + 2 + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.pPORT_NUM(N), .pDATA_WIDTH(W)) bus ();

  mem_arbiter_rr #(.pPORT_NUM(N), .pDATA_WIDTH(W), .pTIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus.slave)
  );

  logic [N-1:0] en;
  logic [1:0]   info_a [N];
  logic [1:0]   xb_a   [N];
  logic [W-1:0] dat_a  [N];

  assign bus.i_en_port = en;
  for (genvar g = 0; g < N; g++) begin : g_drv
    assign bus.i_info[2*g +: 2]       = info_a[g];
    assign bus.i_extra_byte[2*g +: 2] = xb_a[g];
    assign bus.i_data[g*W +: W]       = dat_a[g];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic e, input logic [1:0] inf,
                          input logic [1:0] xb, input logic [W-1:0] d);
    en[p]     = e;
    info_a[p] = inf;
    xb_a[p]   = xb;
    dat_a[p]  = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 2'b00, 2'b00, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model state: locked flag, owner, last granted port, idle cycles of owner.
  logic [N-1:0]   m_ack, m_ack_last;
  bit             m_locked;
  int             m_owner, m_last, m_idle, m_win, m_p;
  bit             p_drop, p_abort;
  logic [1:0]     m_info;
  logic [TPW-1:0] held, exp_t;
  logic [TPW-1:0] exp_q[$];

  always begin : scoreboard
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      held = '0; p_drop = 1'b0; p_abort = 1'b0;
      m_locked = 1'b0; m_owner = 0; m_last = N - 1; m_idle = 0; m_ack_last = '0;
    end else begin
      n_checks++;
      if ({bus.o_abort, bus.o_drop} !== {p_abort, p_drop})
        $display("FAIL sb_pulses abort,drop got=%b%b exp=%b%b", bus.o_abort, bus.o_drop, p_abort, p_drop);
      else n_pass++;
      n_checks++;
      if (bus.o_en_mem !== (exp_q.size() != 0))
        $display("FAIL sb_en_mem got=%b exp=%b", bus.o_en_mem, (exp_q.size() != 0));
      else n_pass++;
      if (exp_q.size() != 0) exp_t = exp_q.pop_front();
      else exp_t = held;
      held = exp_t;
      n_checks++;
      if ({bus.o_port_num, bus.o_info_port, bus.o_extra_byte, bus.o_data} !== exp_t)
        $display("FAIL sb_word got=%h exp=%h",
                 {bus.o_port_num, bus.o_info_port, bus.o_extra_byte, bus.o_data}, exp_t);
      else n_pass++;

      m_ack = '0; p_drop = 1'b0; p_abort = 1'b0;
      if (!m_locked) begin
        m_win = -1;
        for (int k = 1; k <= N; k++) begin
          m_p = (m_last + k) % N;
          if (m_win < 0 && en[m_p] && (info_a[m_p] == 2'b01 || info_a[m_p] == 2'b11)) m_win = m_p;
        end
        for (int p = 0; p < N; p++)
          if (en[p] && (info_a[p] == 2'b00 || info_a[p] == 2'b10)) begin
            m_ack[p] = 1'b1;
            p_drop   = 1'b1;
          end
        if (m_win >= 0) begin
          m_ack[m_win] = 1'b1;
          exp_q.push_back({PW'(m_win), info_a[m_win], xb_a[m_win], dat_a[m_win]});
          m_last = m_win;
          if (info_a[m_win] == 2'b01) begin
            m_locked = 1'b1; m_owner = m_win; m_idle = 0;
          end
        end
      end else if (en[m_owner]) begin
        m_ack[m_owner] = 1'b1;
        m_info = (info_a[m_owner] == 2'b01) ? 2'b10 : info_a[m_owner];
        exp_q.push_back({PW'(m_owner), m_info, xb_a[m_owner], dat_a[m_owner]});
        m_idle = 0;
        if (info_a[m_owner] != 2'b00) m_locked = 1'b0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          p_abort = 1'b1; m_locked = 1'b0; m_idle = 0;
        end
      end
      n_checks++;
      if (bus.o_ack !== m_ack) $display("FAIL sb_ack got=%b exp=%b", bus.o_ack, m_ack);
      else n_pass++;
      m_ack_last = m_ack;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    set_port(1, 1'b1, 2'b01, 2'b00, 32'h0000_00A1);
    #3;
    n_checks++;
    if (bus.o_ack !== 3'b000) $display("FAIL rst_ack got=%b exp=000", bus.o_ack); else n_pass++;
    n_checks++;
    if ({bus.o_en_mem, bus.o_data, bus.o_port_num, bus.o_info_port, bus.o_extra_byte,
         bus.o_abort, bus.o_drop} !== '0)
      $display("FAIL rst_outs en=%b data=%h port=%0d", bus.o_en_mem, bus.o_data, bus.o_port_num);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    n_checks++;
    if (bus.o_ack !== 3'b010) $display("FAIL rst_first_grant got=%b exp=010", bus.o_ack); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.o_en_mem, bus.o_port_num, bus.dbg_locked} !== {1'b1, PW'(1), 1'b1})
      $display("FAIL rst_lock1 got=%b/%0d/%b exp=1/1/1", bus.o_en_mem, bus.o_port_num, bus.dbg_locked);
    else n_pass++;
    set_port(1, 1'b1, 2'b00, 2'b00, 32'h0000_00A2);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_ack, bus.o_en_mem, bus.o_data, bus.o_port_num, bus.o_info_port,
         bus.o_extra_byte, bus.o_abort, bus.o_drop} !== '0)
      $display("FAIL rst_midframe ack=%b en=%b data=%h abort=%b", bus.o_ack, bus.o_en_mem, bus.o_data, bus.o_abort);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 2'b01, 2'b00, 32'h0000_00B0);
    set_port(1, 1'b1, 2'b01, 2'b00, 32'h0000_00B1);
    #3;
    n_checks++;
    if (bus.o_ack !== 3'b001) $display("FAIL rst_prio got=%b exp=001", bus.o_ack); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.o_en_mem, bus.o_port_num, bus.o_info_port} !== {1'b1, PW'(0), 2'b01})
      $display("FAIL rst_prio_wr got=%b/%0d/%b exp=1/0/01", bus.o_en_mem, bus.o_port_num, bus.o_info_port);
    else n_pass++;
    set_port(0, 1'b1, 2'b10, 2'b00, 32'h0000_00B2);
    set_port(1, 1'b0, 2'b00, 2'b00, '0);
    @(negedge clk);
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if ({bus.o_en_mem, bus.o_port_num} !== {1'b1, PW'((c - 1) % 3)})
          $display("FAIL rr_seq c=%0d got=%b/%0d exp=1/%0d", c, bus.o_en_mem, bus.o_port_num, (c - 1) % 3);
        else n_pass++;
      end
      if (c == 6) break;
      for (int p = 0; p < N; p++) set_port(p, 1'b1, 2'b11, 2'(p), 32'hC000_0000 + p);
      #3;
      e = '0;
      e[c % 3] = 1'b1;
      n_checks++;
      if (bus.o_ack !== e) $display("FAIL rr_ack c=%0d got=%b exp=%b", c, bus.o_ack, e); else n_pass++;
    end
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_lock();
    logic [1:0]   inf2 [5];
    logic         en0  [5];
    logic [N-1:0] eack [5];
    int           wport[5];
    logic [1:0]   winf [5];
    inf2 = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    en0  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eack = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    wport = '{2, 2, 2, 2, 0};
    winf = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if ({bus.o_en_mem, bus.o_port_num, bus.o_info_port} !== {1'b1, PW'(wport[c-1]), winf[c-1]})
          $display("FAIL lock_wr c=%0d got=%b/%0d/%b exp=1/%0d/%b", c, bus.o_en_mem,
                   bus.o_port_num, bus.o_info_port, wport[c-1], winf[c-1]);
        else n_pass++;
      end
      if (c == 5) break;
      set_port(2, (c < 4), inf2[c], 2'b01, 32'hD200_0000 + c);
      set_port(0, en0[c], 2'b01, 2'b00, 32'hD000_0000);
      #3;
      n_checks++;
      if (bus.o_ack !== eack[c]) $display("FAIL lock_ack c=%0d got=%b exp=%b", c, bus.o_ack, eack[c]);
      else n_pass++;
    end
    set_port(0, 1'b1, 2'b10, 2'b10, 32'hD000_0001);
    @(negedge clk);
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_orphan_drop();
    do_reset();
    @(negedge clk);
    set_port(1, 1'b1, 2'b00, 2'b00, 32'hE100_0000);
    set_port(0, 1'b1, 2'b01, 2'b00, 32'hE000_0000);
    #3;
    n_checks++;
    if (bus.o_ack !== 3'b011) $display("FAIL orph_ack got=%b exp=011", bus.o_ack); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.o_en_mem, bus.o_port_num, bus.o_drop} !== {1'b1, PW'(0), 1'b1})
      $display("FAIL orph_wr got=%b/%0d/%b exp=1/0/1", bus.o_en_mem, bus.o_port_num, bus.o_drop);
    else n_pass++;
    set_port(1, 1'b0, 2'b00, 2'b00, '0);
    set_port(0, 1'b1, 2'b10, 2'b00, 32'hE000_0001);
    @(negedge clk);
    n_checks++;
    if ({bus.o_drop, bus.o_port_num, bus.o_info_port} !== {1'b0, PW'(0), 2'b10})
      $display("FAIL orph_after got=%b/%0d/%b exp=0/0/10", bus.o_drop, bus.o_port_num, bus.o_info_port);
    else n_pass++;
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    set_port(0, 1'b1, 2'b01, 2'b00, 32'hF000_0000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_abort !== 1'b0) $display("FAIL tmo_early c=%0d got=%b exp=0", c, bus.o_abort); else n_pass++;
      set_port(0, 1'b0, 2'b00, 2'b00, '0);
      set_port(1, 1'b1, 2'b01, 2'b00, 32'hF100_0000);
      #3;
      n_checks++;
      if (bus.o_ack !== 3'b000) $display("FAIL tmo_blocked c=%0d got=%b exp=000", c, bus.o_ack); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({bus.o_abort, bus.o_en_mem, bus.dbg_locked} !== 3'b100)
      $display("FAIL tmo_abort got=%b/%b/%b exp=1/0/0", bus.o_abort, bus.o_en_mem, bus.dbg_locked);
    else n_pass++;
    #3;
    n_checks++;
    if (bus.o_ack !== 3'b010) $display("FAIL tmo_regrant got=%b exp=010", bus.o_ack); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.o_abort, bus.o_en_mem, bus.o_port_num} !== {1'b0, 1'b1, PW'(1)})
      $display("FAIL tmo_once got=%b/%b/%0d exp=0/1/1", bus.o_abort, bus.o_en_mem, bus.o_port_num);
    else n_pass++;
    set_port(1, 1'b1, 2'b10, 2'b00, 32'hF100_0001);
    @(negedge clk);
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap_resync();
    int           pt  [9];
    logic [1:0]   it  [9];
    logic [1:0]   xt  [9];
    logic [1:0]   wt  [9];
    logic [N-1:0] at  [9];
    pt = '{2, 2, 2, 1, 0, 0, 0, 1, 1};
    it = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b10};
    xt = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
    wt = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10};
    at = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if ({bus.o_port_num, bus.o_info_port, bus.o_extra_byte} !== {PW'(pt[c-1]), wt[c-1], xt[c-1]})
          $display("FAIL wrap_wr c=%0d got=%0d/%b/%b exp=%0d/%b/%b", c, bus.o_port_num,
                   bus.o_info_port, bus.o_extra_byte, pt[c-1], wt[c-1], xt[c-1]);
        else n_pass++;
      end
      idle_all();
      if (c == 9) break;
      set_port(pt[c], 1'b1, it[c], xt[c], 32'h5A00_0000 + c);
      #3;
      n_checks++;
      if (bus.o_ack !== at[c]) $display("FAIL wrap_ack c=%0d got=%b exp=%b", c, bus.o_ack, at[c]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int rem [N];
    int gap [N];
    do_reset();
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      gap[p] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (en[p] && m_ack_last[p]) en[p] = 1'b0;
        if (!en[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if ($urandom_range(0, 4) == 0) gap[p] = $urandom_range(1, 7);
          else begin
            if (rem[p] == 0) begin
              if ($urandom_range(0, 9) == 0) info_a[p] = 2'b00;
              else begin
                rem[p]    = $urandom_range(0, 4);
                info_a[p] = (rem[p] == 0) ? 2'b11 : 2'b01;
              end
            end else begin
              rem[p]--;
              info_a[p] = (rem[p] == 0) ? 2'b10 : 2'b00;
            end
            xb_a[p]  = 2'($urandom_range(0, 3));
            dat_a[p] = $urandom;
            en[p]    = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    idle_all();
    repeat (TMO + 3) @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_all();
    test_reset();
    test_round_robin();
    test_frame_lock();
    test_orphan_drop();
    test_timeout();
    test_wrap_resync();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
